// File: rtl/tmds_rx_decoder.sv
// TMDS receive channel: hunts for symbol alignment on DVI control tokens,
// then decodes each 10-bit symbol into video data or control bits.
module tmds_rx_decoder #(
    parameter int LOCK_COUNT   = 8,
    parameter int TOKEN_WINDOW = 1600
) (
    input  logic       pixelClk,
    input  logic       reset,
    input  logic [9:0] rawWord,
    output logic [7:0] dataOut,
    output logic [1:0] ctrlOut,
    output logic       de,
    output logic       aligned,
    output logic [3:0] slipPos,
    output logic       slipPulse
);
    // state  | meaning
    // SEARCH | counting consecutive tokens at slipPos, slipping after a window
    // LOCKED | alignment found, decoding; drop back if tokens stop arriving
    typedef enum logic {SEARCH, LOCKED} state_t;

    localparam int WIN_W = (TOKEN_WINDOW > 2) ? $clog2(TOKEN_WINDOW) : 1;
    localparam int TOK_W = $clog2(LOCK_COUNT + 1);
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(TOKEN_WINDOW - 1);
    localparam logic [TOK_W-1:0] TOK_LAST = TOK_W'(LOCK_COUNT - 1);

    state_t           state;
    logic [9:0]       prevWord;
    logic [9:0]       symbol;
    logic [19:0]      hist;
    logic [WIN_W-1:0] winCnt;
    logic [TOK_W-1:0] tokCnt;
    logic [1:0]       holdoff;

    logic       isToken;
    logic [1:0] tokVal;
    logic [7:0] dWord;
    logic [7:0] dataDec;
    logic       evalNow;
    logic       lockNow;
    logic       dropNow;
    logic       alignedNext;

    assign hist = {rawWord, prevWord};

    always_comb begin
        isToken = 1'b1;
        tokVal  = 2'b00;
        case (symbol)
            10'b1101010100: tokVal = 2'b00;
            10'b0010101011: tokVal = 2'b01;
            10'b0101010100: tokVal = 2'b10;
            10'b1010101011: tokVal = 2'b11;
            default:        isToken = 1'b0;
        endcase
    end

    always_comb begin
        dWord      = symbol[9] ? ~symbol[7:0] : symbol[7:0];
        dataDec    = 8'h00;
        dataDec[0] = dWord[0];
        for (int i = 1; i < 8; i++) begin
            dataDec[i] = symbol[8] ? (dWord[i] ^ dWord[i-1]) : ~(dWord[i] ^ dWord[i-1]);
        end
    end

    // Stage-2 output gating follows the alignment status being registered on the same edge.
    always_comb begin
        evalNow     = (holdoff == 2'd0);
        lockNow     = (state == SEARCH) && evalNow && isToken && (tokCnt == TOK_LAST);
        dropNow     = (state == LOCKED) && evalNow && !isToken && (winCnt == WIN_LAST);
        alignedNext = lockNow || ((state == LOCKED) && !dropNow);
    end

    always_ff @(posedge pixelClk) begin
        if (reset) begin
            state     <= SEARCH;
            prevWord  <= 10'd0;
            symbol    <= 10'd0;
            slipPos   <= 4'd0;
            winCnt    <= '0;
            tokCnt    <= '0;
            holdoff   <= 2'd0;
            slipPulse <= 1'b0;
            aligned   <= 1'b0;
            de        <= 1'b0;
            dataOut   <= 8'h00;
            ctrlOut   <= 2'b00;
        end else begin
            prevWord  <= rawWord;
            symbol    <= hist[slipPos +: 10];
            slipPulse <= 1'b0;

            if (!evalNow) begin
                holdoff <= holdoff - 2'd1;
            end else begin
                case (state)
                    SEARCH: begin
                        if (lockNow) begin
                            state  <= LOCKED;
                            tokCnt <= '0;
                            winCnt <= '0;
                        end else if (winCnt == WIN_LAST) begin
                            slipPos   <= (slipPos == 4'd9) ? 4'd0 : slipPos + 4'd1;
                            slipPulse <= 1'b1;
                            tokCnt    <= '0;
                            winCnt    <= '0;
                            holdoff   <= 2'd2;
                        end else begin
                            tokCnt <= isToken ? tokCnt + TOK_W'(1) : '0;
                            winCnt <= winCnt + WIN_W'(1);
                        end
                    end
                    LOCKED: begin
                        if (isToken) begin
                            winCnt <= '0;
                        end else if (dropNow) begin
                            state  <= SEARCH;
                            tokCnt <= '0;
                            winCnt <= '0;
                        end else begin
                            winCnt <= winCnt + WIN_W'(1);
                        end
                    end
                    default: state <= SEARCH;
                endcase
            end

            aligned <= alignedNext;
            if (!alignedNext) begin
                de      <= 1'b0;
                dataOut <= 8'h00;
                ctrlOut <= 2'b00;
            end else if (isToken) begin
                de      <= 1'b0;
                dataOut <= 8'h00;
                ctrlOut <= tokVal;
            end else begin
                de      <= 1'b1;
                dataOut <= dataDec;
            end
        end
    end
endmodule

// File: tb/tb_tmds_rx_decoder.sv
// Self-checking bench for tmds_rx_decoder: directed lock/slip scenarios plus
// randomized symbols checked against a table/arithmetic reference decoder.
module tb_tmds_rx_decoder;
    localparam int LOCK_COUNT   = 8;
    localparam int TOKEN_WINDOW = 32;
    localparam logic [9:0] T0 = 10'h354;
    localparam logic [9:0] T1 = 10'h0AB;
    localparam logic [9:0] T2 = 10'h154;
    localparam logic [9:0] T3 = 10'h2AB;

    logic       pixelClk = 1'b0;
    logic       reset    = 1'b1;
    logic [9:0] rawWord  = 10'd0;
    logic [7:0] dataOut;
    logic [1:0] ctrlOut;
    logic       de;
    logic       aligned;
    logic [3:0] slipPos;
    logic       slipPulse;

    int checks = 0;
    int errors = 0;

    logic [9:0] tokTab [4] = '{T0, T1, T2, T3};
    bit         streamBits[$];
    logic [9:0] streamTok[$];

    tmds_rx_decoder #(.LOCK_COUNT(LOCK_COUNT), .TOKEN_WINDOW(TOKEN_WINDOW)) dut (
        .pixelClk (pixelClk),
        .reset    (reset),
        .rawWord  (rawWord),
        .dataOut  (dataOut),
        .ctrlOut  (ctrlOut),
        .de       (de),
        .aligned  (aligned),
        .slipPos  (slipPos),
        .slipPulse(slipPulse)
    );

    always #5 pixelClk = ~pixelClk;

    function automatic int refCtrl(input logic [9:0] s);
        for (int k = 0; k < 4; k++) if (s == tokTab[k]) return k;
        return -1;
    endfunction

    // Transition-minimised data: undo optional inversion, then XOR/XNOR chain.
    function automatic logic [7:0] refData(input logic [9:0] s);
        logic [7:0] d, x;
        d = s[9] ? ~s[7:0] : s[7:0];
        x = d ^ {d[6:0], 1'b0};
        return s[8] ? x : ((~x & 8'hFE) | (d & 8'h01));
    endfunction

    function automatic logic [9:0] randNonToken();
        logic [9:0] w;
        do w = 10'($urandom_range(0, 1023)); while (refCtrl(w) >= 0);
        return w;
    endfunction

    task automatic tick(input logic [9:0] w);
        rawWord = w;
        @(posedge pixelClk);
        #1;
    endtask

    // Serial bit stream of tokens, with the first token starting at bit 'offset'.
    task automatic buildStream(input int offset, input int nTok, input int randFrom);
        logic [9:0] t;
        streamBits.delete();
        streamTok.delete();
        for (int b = 0; b < offset; b++) streamBits.push_back(1'b0);
        for (int k = 0; k < nTok; k++) begin
            t = (k < randFrom) ? T0 : tokTab[$urandom_range(0, 3)];
            streamTok.push_back(t);
            for (int b = 0; b < 10; b++) streamBits.push_back(t[b]);
        end
    endtask

    function automatic logic [9:0] wordAt(input int n);
        logic [9:0] w;
        for (int b = 0; b < 10; b++) w[b] = streamBits[10*n + b];
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick(10'($urandom));
            checks++;
            if ({dataOut, ctrlOut, de, aligned, slipPos, slipPulse} !== 17'd0) begin
                errors++;
                $display("FAIL reset cycle %0d: got d=%h c=%b de=%b a=%b pos=%0d pulse=%b, expected all zero",
                         c, dataOut, ctrlOut, de, aligned, slipPos, slipPulse);
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_offset0_lock();
        logic [9:0] seq[$];
        logic [9:0] o;
        logic       expA, expDe;
        logic [7:0] expD;
        logic [1:0] expC, ctrlHold;
        int         c;
        for (int k = 0; k < 20; k++) seq.push_back(T0);
        seq.push_back(10'h100);
        seq.push_back(10'h0FF);
        for (int k = 0; k < 32; k++)
            seq.push_back((k % 8 == 7 || $urandom_range(0, 3) == 0) ? tokTab[$urandom_range(0, 3)]
                                                                    : randNonToken());
        ctrlHold = 2'b00;
        for (int i = 0; i < seq.size(); i++) begin
            tick(seq[i]);
            if (i < 9) begin
                expA = 1'b0; expDe = 1'b0; expD = 8'h00; expC = 2'b00;
            end else begin
                o = seq[i-2];
                c = refCtrl(o);
                expA = 1'b1;
                if (c >= 0) begin
                    expDe = 1'b0; expD = 8'h00; expC = 2'(c); ctrlHold = 2'(c);
                end else begin
                    expDe = 1'b1; expD = refData(o); expC = ctrlHold;
                end
            end
            checks++;
            if ({aligned, de, dataOut, ctrlOut} !== {expA, expDe, expD, expC}) begin
                errors++;
                $display("FAIL lock0 step %0d: got a=%b de=%b d=%h c=%b, expected a=%b de=%b d=%h c=%b",
                         i, aligned, de, dataOut, ctrlOut, expA, expDe, expD, expC);
            end
            checks++;
            if ({slipPulse, slipPos} !== 5'd0) begin
                errors++;
                $display("FAIL lock0_noslip step %0d: got pulse=%b pos=%0d, expected 0/0", i, slipPulse, slipPos);
            end
        end
    endtask

    task automatic test_control_decode();
        logic [9:0] seq [8]  = '{T0, T1, T2, T3, 10'h100, 10'h0FF, T0, T0};
        logic [1:0] expC [6] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11, 2'b11};
        logic       expDe[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
        logic [7:0] expD [6] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        for (int i = 0; i < 8; i++) begin
            tick(seq[i]);
            if (i >= 2) begin
                checks++;
                if ({aligned, de, dataOut, ctrlOut} !== {1'b1, expDe[i-2], expD[i-2], expC[i-2]}) begin
                    errors++;
                    $display("FAIL ctrl_decode sym %0d: got a=%b de=%b d=%h c=%b, expected a=1 de=%b d=%h c=%b",
                             i - 2, aligned, de, dataOut, ctrlOut, expDe[i-2], expD[i-2], expC[i-2]);
                end
            end
        end
    endtask

    task automatic test_lock_loss();
        logic [9:0] seq[$];
        logic       expA, expDe;
        int         o;
        seq.push_back(T0);
        seq.push_back(T0);
        for (int k = 0; k < 32; k++) seq.push_back(10'h100);
        for (int k = 0; k < 12; k++) seq.push_back(T0);
        for (int i = 0; i < seq.size(); i++) begin
            tick(seq[i]);
            if (i < 2) continue;
            o = i - 2;
            expA  = (o <= 32) || (o >= 41);
            expDe = (o >= 2) && (o <= 32);
            checks++;
            if ({aligned, de, dataOut, ctrlOut} !== {expA, expDe, 8'h00, 2'b00}) begin
                errors++;
                $display("FAIL lock_loss sym %0d: got a=%b de=%b d=%h c=%b, expected a=%b de=%b d=00 c=00",
                         o, aligned, de, dataOut, ctrlOut, expA, expDe);
            end
            checks++;
            if ({slipPulse, slipPos} !== 5'd0) begin
                errors++;
                $display("FAIL lock_loss_noslip sym %0d: got pulse=%b pos=%0d, expected 0/0", o, slipPulse, slipPos);
            end
        end
    endtask

    task automatic test_misaligned();
        int         pulses[$];
        logic       expPulse, expA;
        logic [3:0] expPos;
        buildStream(3, 150, 115);
        reset = 1'b1;
        tick(10'($urandom));
        reset = 1'b0;
        for (int i = 0; i < 140; i++) begin
            tick(wordAt(i));
            if (slipPulse === 1'b1) pulses.push_back(i);
            expPulse = (i == 31) || (i == 65) || (i == 99);
            expPos   = (i < 31) ? 4'd0 : (i < 65) ? 4'd1 : (i < 99) ? 4'd2 : 4'd3;
            expA     = (i >= 109);
            checks++;
            if ({slipPulse, slipPos, aligned} !== {expPulse, expPos, expA}) begin
                errors++;
                $display("FAIL misalign step %0d: got pulse=%b pos=%0d a=%b, expected pulse=%b pos=%0d a=%b",
                         i, slipPulse, slipPos, aligned, expPulse, expPos, expA);
            end
            if (i >= 109) begin
                checks++;
                if ({de, ctrlOut} !== {1'b0, 2'(refCtrl(streamTok[i-2]))}) begin
                    errors++;
                    $display("FAIL misalign_ctrl step %0d: got de=%b c=%b, expected de=0 c=%b",
                             i, de, ctrlOut, 2'(refCtrl(streamTok[i-2])));
                end
            end
        end
        checks++;
        if (pulses.size() != 3) begin
            errors++;
            $display("FAIL misalign_pulse_count: got %0d, expected 3", pulses.size());
        end else begin
            checks++;
            if (pulses[1] - pulses[0] != 34 || pulses[2] - pulses[1] != 34) begin
                errors++;
                $display("FAIL misalign_spacing: got %0d,%0d, expected 34,34",
                         pulses[1] - pulses[0], pulses[2] - pulses[1]);
            end
        end
    endtask

    task automatic test_reset_mid_lock();
        int n = 0;
        int firstA;
        int pulseCnt;
        buildStream(5, 460, 1000);
        reset = 1'b1;
        tick(10'($urandom));
        reset = 1'b0;
        firstA = -1;
        for (int i = 0; i < 250 && firstA < 0; i++) begin
            tick(wordAt(n++));
            if (aligned === 1'b1) firstA = i;
        end
        checks++;
        if (firstA != 177 || slipPos !== 4'd5) begin
            errors++;
            $display("FAIL mid_lock_initial: got lock step %0d pos=%0d, expected step 177 pos=5", firstA, slipPos);
        end
        for (int i = 0; i < 3; i++) tick(wordAt(n++));
        reset = 1'b1;
        tick(wordAt(n++));
        reset = 1'b0;
        checks++;
        if ({aligned, slipPos, de, slipPulse} !== 7'd0) begin
            errors++;
            $display("FAIL mid_lock_reset: got a=%b pos=%0d de=%b pulse=%b, expected all zero",
                     aligned, slipPos, de, slipPulse);
        end
        firstA   = -1;
        pulseCnt = 0;
        for (int i = 0; i < 250 && firstA < 0; i++) begin
            tick(wordAt(n++));
            if (slipPulse === 1'b1) pulseCnt++;
            if (aligned === 1'b1) firstA = i;
        end
        checks++;
        if (firstA != 177 || pulseCnt != 5 || slipPos !== 4'd5) begin
            errors++;
            $display("FAIL mid_lock_relock: got step %0d pulses %0d pos=%0d, expected step 177 pulses 5 pos=5",
                     firstA, pulseCnt, slipPos);
        end
    endtask

    initial begin
        test_reset();
        test_offset0_lock();
        test_control_decode();
        test_lock_loss();
        test_misaligned();
        test_reset_mid_lock();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/tmds_rx_decoder.md
Name: tmds_rx_decoder

Overview:
- Receive-side counterpart of the HDMI/DVI transmit path; one instance per TMDS channel.
- Accepts one raw 10-bit word per pixel clock from an upstream 1:10 deserializer; word boundaries are arbitrary.
- Finds symbol alignment by hunting for DVI control tokens with an internal barrel window, then decodes each symbol to 8-bit video data or 2-bit control plus a data-enable.
- Output feeds the video capture / sync-recovery logic.

Parameters:
- LOCK_COUNT, 8: consecutive control tokens required at one offset to declare lock.
- TOKEN_WINDOW, 1600: words without a lock (SEARCH) or without any token (LOCKED) before slipping or dropping lock. Counter width must hold TOKEN_WINDOW-1.

Ports:
- pixelClk, in, 1: pixel/word clock; all logic on its rising edge.
- reset, in, 1: synchronous, active-high.
- rawWord, in, 10: deserialized bits; bit 0 is the earliest received.
- dataOut, out, 8: decoded video byte.
- ctrlOut, out, 2: decoded control bits; for the blue channel these are {vSync,hSync}.
- de, out, 1: high when dataOut holds a decoded data symbol.
- aligned, out, 1: lock status.
- slipPos, out, 4: current window offset, 0..9.
- slipPulse, out, 1: one-cycle pulse on each offset change.

Behaviour:
- Reset: synchronous, active-high, and applies mid-operation. The next edge gives: state=SEARCH, slipPos=0, all counters 0, prevWord=0, holdoff=0, and dataOut=0, ctrlOut=0, de=0, aligned=0, slipPulse=0.
- Pipeline:
  - prevWord<=rawWord.
  - hist={rawWord,prevWord} (20 bits).
  - Stage 1: symbol<=hist[slipPos+9:slipPos].
  - Stage 2: outputs<=decode(symbol).
  - With slipPos=0, the word on rawWord at edge n appears on the outputs after edge n+2. Latency is fixed at 2 cycles.
- Control tokens (symbol[9:0] -> ctrl):
  - 1101010100 -> 00
  - 0010101011 -> 01
  - 0101010100 -> 10
  - 1010101011 -> 11
- Data decode:
  - d = symbol[9] ? ~symbol[7:0] : symbol[7:0].
  - D[0]=d[0].
  - For i=1..7: D[i] = symbol[8] ? d[i]^d[i-1] : ~(d[i]^d[i-1]).
- Output rules:
  - aligned=0: de=0, dataOut=0, ctrlOut=0.
  - aligned=1 and token: de=0, ctrlOut=token value, dataOut=0.
  - aligned=1 and non-token: de=1, dataOut=D, ctrlOut holds its previous value.
- Holdoff: for 2 cycles after any slipPos change, stage-1 symbols are not evaluated. No counting, no state change.
- FSM SEARCH:
  - Each evaluated symbol: token -> tokCnt+1; non-token -> tokCnt=0. winCnt increments every evaluated cycle.
  - tokCnt reaching LOCK_COUNT (the token that makes it LOCK_COUNT) -> LOCKED. aligned=1 from the same edge that stage 2 registers that token. winCnt=0.
  - winCnt==TOKEN_WINDOW-1 without lock -> slipPos<=(slipPos==9)?0:slipPos+1, slipPulse=1 for one cycle, tokCnt=0, winCnt=0, holdoff starts.
  - Lock and slip on the same cycle: lock wins, no slip.
- FSM LOCKED:
  - Token -> winCnt=0; non-token -> winCnt+1.
  - winCnt==TOKEN_WINDOW-1 -> SEARCH, aligned=0, tokCnt=0, winCnt=0, slipPos unchanged (re-search starts at the last good offset).
- slipPos wraps 9->0 indefinitely. There is no give-up state.

Test Plan:
1. Reset: drive random rawWord and hold reset 2 cycles -> dataOut=0, ctrlOut=0, de=0, aligned=0, slipPos=0, slipPulse=0 one edge after reset is first sampled.
2. Offset-0 lock (TOKEN_WINDOW=32):
   - Stimulus: 20 words 10'b1101010100, then 10'h100, then 10'h0FF.
   - Response: aligned=1 coincident with the 8th token on the outputs, ctrlOut=00, de=0; then de=1 with dataOut=8'h00, then dataOut=8'hFF, each exactly 2 cycles after input; slipPulse never asserted.
3. Misaligned stream: continuous token bit-stream whose true boundary sits at rawWord bit 3 (TOKEN_WINDOW=32) -> exactly 3 slipPulse pulses spaced 34 cycles apart; slipPos steps 0,1,2,3; aligned=1 with slipPos=3; decoded ctrlOut correct.
4. Control decode: after lock, feed the four tokens in order -> ctrlOut=00,01,10,11 on consecutive cycles, de=0; then data 10'h100 -> de=1, ctrlOut holds 11.
5. Lock loss: after lock, feed 32 consecutive 10'h100 words (TOKEN_WINDOW=32) -> aligned falls after the 32nd, de forced 0, slipPos unchanged; re-feeding 8 tokens relocks without any slipPulse.
6. Reset mid-lock: assert reset 1 cycle while aligned=1 at slipPos=5 -> next edge aligned=0, slipPos=0, de=0; must then slip back to 5 to relock.
